// File: rtl/timer_share_arbiter.sv
// Shares one prescaled tick down-counter among NUM_REQ requesters, granting one at a time.
// Define TIMER_ARB_FIXED_PRIORITY_EN for lowest-index-wins arbitration instead of round-robin.
module timer_share_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int TICK_DIV = 2000000,
  parameter int DIV_W    = 21,
  parameter int TICKS_W  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*TICKS_W-1:0] req_ticks,
  output logic [NUM_REQ-1:0]         grant,
  output logic [NUM_REQ-1:0]         done,
  output logic                       busy
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [PTR_W-1:0]   PTR_LAST = PTR_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_next;
  logic [DIV_W-1:0]   prescaler, prescaler_next;
  logic [TICKS_W-1:0] remaining, remaining_next;
  logic [PTR_W-1:0]   owner, owner_next, owner_inc, winner;
  logic [TICKS_W-1:0] winner_ticks;
  logic               found;
  logic [NUM_REQ-1:0] grant_next, done_next;
  logic               busy_next;
`ifndef TIMER_ARB_FIXED_PRIORITY_EN
  logic [PTR_W-1:0]   rr_ptr, rr_ptr_next;
`endif

  assign owner_inc    = (owner == PTR_LAST) ? '0 : owner + 1'b1;
  assign winner_ticks = req_ticks[int'(winner)*TICKS_W +: TICKS_W];

  // Winner search: first pending request starting at rr_ptr (or index 0), wrapping.
  always_comb begin
    int idx;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
`ifdef TIMER_ARB_FIXED_PRIORITY_EN
      idx = i;
`else
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
`endif
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    state_next     = state;
    prescaler_next = prescaler;
    remaining_next = remaining;
    owner_next     = owner;
    grant_next     = grant;
    done_next      = '0;
    busy_next      = busy;
`ifndef TIMER_ARB_FIXED_PRIORITY_EN
    rr_ptr_next    = rr_ptr;
`endif
    case (state)
      IDLE: begin
        grant_next = '0;
        busy_next  = 1'b0;
        if (found) begin
          owner_next     = winner;
          remaining_next = winner_ticks;
          prescaler_next = '0;
          busy_next      = 1'b1;
          if (winner_ticks != '0) begin
            state_next = RUN;
            grant_next = ONE_HOT0 << winner;
          end else begin
            state_next = DONE;
            done_next  = ONE_HOT0 << winner;
          end
        end
      end
      RUN: begin
        // An owner dropping req wins over a simultaneous final wrap: abort, no done.
        if (!req[owner]) begin
          state_next = IDLE;
          grant_next = '0;
          busy_next  = 1'b0;
`ifndef TIMER_ARB_FIXED_PRIORITY_EN
          rr_ptr_next = owner_inc;
`endif
        end else if (prescaler == DIV_LAST) begin
          prescaler_next = '0;
          remaining_next = remaining - 1'b1;
          if (remaining == TICKS_W'(1)) begin
            state_next = DONE;
            grant_next = '0;
            done_next  = ONE_HOT0 << owner;
          end
        end else begin
          prescaler_next = prescaler + 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
        grant_next = '0;
        busy_next  = 1'b0;
`ifndef TIMER_ARB_FIXED_PRIORITY_EN
        rr_ptr_next = owner_inc;
`endif
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      prescaler <= '0;
      remaining <= '0;
      owner     <= '0;
      grant     <= '0;
      done      <= '0;
      busy      <= 1'b0;
`ifndef TIMER_ARB_FIXED_PRIORITY_EN
      rr_ptr    <= '0;
`endif
    end else begin
      state     <= state_next;
      prescaler <= prescaler_next;
      remaining <= remaining_next;
      owner     <= owner_next;
      grant     <= grant_next;
      done      <= done_next;
      busy      <= busy_next;
`ifndef TIMER_ARB_FIXED_PRIORITY_EN
      rr_ptr    <= rr_ptr_next;
`endif
    end
  end
endmodule
